frame_fetch_loader: RTL and testbench

Upstream feeder for the 3D recursive-search motion estimator. Reads 64-bit words from external frame memory and streams them over one shared 64-bit bus into the current-block register file and the search/update-window register file. Drives the estimator's `cur_data_in`, `cur_WE`, `search_WE`, `curfilled` and `srcfilled` inputs, and answers its `search_WE_req`. One outstanding memory read at a time.

---
 rtl/me_pkg.sv | 25 ++
 rtl/frame_addr_calc.sv | 27 ++
 rtl/frame_fetch_loader.sv | 206 ++++++++++++++++++++
 tb/tb_frame_fetch_loader.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/me_pkg.sv
// Shared constants, FSM state encoding and clamp helper for the frame fetch loader.
package me_pkg;

  localparam int unsigned FRAME_W   = 352;
  localparam int unsigned FRAME_H   = 288;
  localparam int unsigned CUR_WORDS = 32;
  localparam int unsigned SW_H      = 24;
  localparam int unsigned SW_WC     = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CUR_ISSUE,
    ST_CUR_WAIT,
    ST_SW_ISSUE,
    ST_SW_WAIT
  } state_t;

  // Saturate v into [lo, hi].
  function automatic int clamp(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/frame_addr_calc.sv
// Clamps a (row, word column) pair into the frame and forms the word address.
module frame_addr_calc #(
  parameter int unsigned FRAME_W = 352,
  parameter int unsigned FRAME_H = 288,
  parameter int unsigned ADDR_W  = 14
) (
  input  logic signed [15:0]       row,
  input  logic signed [15:0]       col,
  output logic        [ADDR_W-1:0] addr_c
);
  import me_pkg::*;

  localparam int unsigned WORDS_PER_ROW = FRAME_W / 8;

  int row_cl;
  int col_cl;
  int lin;

  // Edge replication by clamping, then row-major word address at full width.
  always_comb begin
    row_cl = clamp(int'(row), 0, int'(FRAME_H) - 1);
    col_cl = clamp(int'(col), 0, int'(WORDS_PER_ROW) - 1);
    lin    = row_cl * int'(WORDS_PER_ROW) + col_cl;
    addr_c = ADDR_W'(lin);
  end

endmodule

// File: rtl/frame_fetch_loader.sv
// Streams current-block and search-window words from frame memory to the estimator register files.
module frame_fetch_loader #(
  parameter int unsigned FRAME_W = me_pkg::FRAME_W,
  parameter int unsigned FRAME_H = me_pkg::FRAME_H,
  parameter int unsigned ADDR_W  = 14,
  parameter int unsigned SW_H    = me_pkg::SW_H,
  parameter int unsigned SW_WC   = me_pkg::SW_WC
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [4:0]         blk_col,
  input  logic [4:0]         blk_row,
  input  logic               search_WE_req,
  input  logic signed [10:0] sw_x,
  input  logic signed [10:0] sw_y,
  output logic               mem_rd,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_valid,
  input  logic [63:0]        mem_data,
  output logic [63:0]        cur_data_in,
  output logic               cur_WE,
  output logic               search_WE,
  output logic               curfilled,
  output logic               srcfilled,
  output logic               busy
);
  import me_pkg::*;

  localparam int unsigned ROW_W    = 8;
  localparam int unsigned COL_W    = 4;
  localparam int unsigned CUR_ROWS = 16;
  localparam int unsigned CUR_WC   = CUR_WORDS / CUR_ROWS;

  state_t             state_q, state_n;
  logic [ROW_W-1:0]   row_q, row_n;
  logic [COL_W-1:0]   col_q, col_n;
  logic [4:0]         blk_col_q, blk_row_q, blk_col_n, blk_row_n;
  logic [4:0]         pend_col_q, pend_row_q;
  logic               pend_start_q;
  logic signed [10:0] sw_x_q, sw_y_q, sw_x_n, sw_y_n;
  logic               last_cur_q, last_sw_q;
  logic               accept_cur, accept_sw, take_data, job_done;
  logic signed [15:0] calc_row, calc_col;
  logic [ADDR_W-1:0]  calc_addr_c;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_n;
  end

  // Next state, job acceptance and word counters.
  always_comb begin
    state_n    = state_q;
    row_n      = row_q;
    col_n      = col_q;
    accept_cur = 1'b0;
    accept_sw  = 1'b0;
    take_data  = 1'b0;
    job_done   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start || pend_start_q) begin
          accept_cur = 1'b1;
          state_n    = ST_CUR_ISSUE;
          row_n      = '0;
          col_n      = '0;
        end else if (search_WE_req) begin
          accept_sw = 1'b1;
          state_n   = ST_SW_ISSUE;
          row_n     = '0;
          col_n     = '0;
        end
      end
      ST_CUR_ISSUE: state_n = ST_CUR_WAIT;
      ST_CUR_WAIT: begin
        if (mem_valid) begin
          take_data = 1'b1;
          state_n   = ST_CUR_ISSUE;
          if (col_q == COL_W'(CUR_WC - 1)) begin
            col_n = '0;
            if (row_q == ROW_W'(CUR_ROWS - 1)) begin
              job_done = 1'b1;
              state_n  = ST_IDLE;
            end else begin
              row_n = row_q + ROW_W'(1);
            end
          end else begin
            col_n = col_q + COL_W'(1);
          end
        end
      end
      ST_SW_ISSUE: state_n = ST_SW_WAIT;
      ST_SW_WAIT: begin
        if (mem_valid) begin
          take_data = 1'b1;
          state_n   = ST_SW_ISSUE;
          if (col_q == COL_W'(SW_WC - 1)) begin
            col_n = '0;
            if (row_q == ROW_W'(SW_H - 1)) begin
              job_done = 1'b1;
              state_n  = ST_IDLE;
            end else begin
              row_n = row_q + ROW_W'(1);
            end
          end else begin
            col_n = col_q + COL_W'(1);
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Job position for the next cycle and the unclamped row/column of the next read.
  always_comb begin
    blk_col_n = blk_col_q;
    blk_row_n = blk_row_q;
    sw_x_n    = sw_x_q;
    sw_y_n    = sw_y_q;
    if (accept_cur) begin
      blk_col_n = start ? blk_col : pend_col_q;
      blk_row_n = start ? blk_row : pend_row_q;
    end
    if (accept_sw) begin
      sw_x_n = sw_x;
      sw_y_n = sw_y;
    end
    if (state_n == ST_SW_ISSUE) begin
      calc_row = 16'(sw_y_n) + 16'(row_n);
      calc_col = 16'(sw_x_n >>> 3) + 16'(col_n);
    end else begin
      calc_row = 16'({blk_row_n, 4'b0000}) + 16'(row_n);
      calc_col = 16'({blk_col_n, 1'b0}) + 16'(col_n);
    end
  end

  frame_addr_calc #(
    .FRAME_W (FRAME_W),
    .FRAME_H (FRAME_H),
    .ADDR_W  (ADDR_W)
  ) u_addr (
    .row    (calc_row),
    .col    (calc_col),
    .addr_c (calc_addr_c)
  );

  // Registered outputs, latched job parameters, pending start and completion flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      row_q        <= '0;
      col_q        <= '0;
      blk_col_q    <= '0;
      blk_row_q    <= '0;
      pend_col_q   <= '0;
      pend_row_q   <= '0;
      pend_start_q <= 1'b0;
      sw_x_q       <= '0;
      sw_y_q       <= '0;
      last_cur_q   <= 1'b0;
      last_sw_q    <= 1'b0;
      mem_rd       <= 1'b0;
      mem_addr     <= '0;
      cur_data_in  <= '0;
      cur_WE       <= 1'b0;
      search_WE    <= 1'b0;
      curfilled    <= 1'b0;
      srcfilled    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      row_q     <= row_n;
      col_q     <= col_n;
      blk_col_q <= blk_col_n;
      blk_row_q <= blk_row_n;
      sw_x_q    <= sw_x_n;
      sw_y_q    <= sw_y_n;

      if (accept_cur) begin
        pend_start_q <= 1'b0;
      end else if (start && (state_q != ST_IDLE)) begin
        pend_start_q <= 1'b1;
        pend_col_q   <= blk_col;
        pend_row_q   <= blk_row;
      end

      mem_rd <= (state_n == ST_CUR_ISSUE) || (state_n == ST_SW_ISSUE);
      if ((state_n == ST_CUR_ISSUE) || (state_n == ST_SW_ISSUE)) mem_addr <= calc_addr_c;

      cur_WE    <= take_data && (state_q == ST_CUR_WAIT);
      search_WE <= take_data && (state_q == ST_SW_WAIT);
      if (take_data) cur_data_in <= mem_data;

      last_cur_q <= job_done && (state_q == ST_CUR_WAIT);
      last_sw_q  <= job_done && (state_q == ST_SW_WAIT);

      if (accept_cur)      curfilled <= 1'b0;
      else if (last_cur_q) curfilled <= 1'b1;
      if (accept_sw)       srcfilled <= 1'b0;
      else if (last_sw_q)  srcfilled <= 1'b1;

      busy <= (state_n != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_frame_fetch_loader.sv
// Directed and randomized checks of frame_fetch_loader against a pixel-arithmetic reference model.
module tb_frame_fetch_loader;

  localparam int FW = 352;
  localparam int FH = 288;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [4:0]         blk_col, blk_row;
  logic               search_WE_req;
  logic signed [10:0] sw_x, sw_y;
  logic               mem_rd;
  logic [13:0]        mem_addr;
  logic               mem_valid;
  logic [63:0]        mem_data;
  logic [63:0]        cur_data_in;
  logic               cur_WE, search_WE, curfilled, srcfilled, busy;

  frame_fetch_loader dut (
    .clk(clk), .reset(reset), .start(start), .blk_col(blk_col), .blk_row(blk_row),
    .search_WE_req(search_WE_req), .sw_x(sw_x), .sw_y(sw_y),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_valid(mem_valid), .mem_data(mem_data),
    .cur_data_in(cur_data_in), .cur_WE(cur_WE), .search_WE(search_WE),
    .curfilled(curfilled), .srcfilled(srcfilled), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_vec = 0;
  int          n_miss = 0;
  int          lat_lo = 1;
  int          lat_hi = 1;
  logic [31:0] key;

  function automatic logic [63:0] mem_word(input int unsigned a);
    return {32'(a) ^ key, ~key ^ (32'(a) * 32'h9E3779B1)};
  endfunction

  // Frame memory: one read at a time, data returned after lat_lo..lat_hi cycles.
  int unsigned rsp_addr;
  int          rsp_lat;
  initial begin
    mem_valid = 1'b0;
    mem_data  = '0;
    forever begin
      @(negedge clk);
      if (mem_rd) begin
        rsp_addr = int'(mem_addr);
        rsp_lat  = int'($urandom_range(lat_hi, lat_lo));
        @(posedge clk);
        repeat (rsp_lat - 1) @(posedge clk);
        #1;
        mem_valid = 1'b1;
        mem_data  = mem_word(rsp_addr);
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
      end
    end
  end

  // Activity recorder.
  int unsigned rd_addr_q[$];
  logic [63:0] cur_data_q[$];
  logic [63:0] sw_data_q[$];
  int n_rd, n_cur, n_sw;
  int first_rd_cyc, last_cur_cyc, first_sw_cyc, cf_cyc;
  bit overlap;

  always @(negedge clk) begin
    if (mem_rd) begin
      rd_addr_q.push_back(int'(mem_addr));
      n_rd++;
      if (first_rd_cyc < 0) first_rd_cyc = cyc;
    end
    if (cur_WE) begin
      cur_data_q.push_back(cur_data_in);
      n_cur++;
      last_cur_cyc = cyc;
    end
    if (search_WE) begin
      sw_data_q.push_back(cur_data_in);
      n_sw++;
      if (first_sw_cyc < 0) first_sw_cyc = cyc;
    end
    if (cur_WE && search_WE) overlap = 1'b1;
    if (curfilled && cf_cyc < 0) cf_cyc = cyc;
  end

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: expected word addresses from pixel coordinates.
  int unsigned exp_cur_q[$];
  int unsigned exp_sw_q[$];

  function automatic int floor8(input int v);
    if (v >= 0) return v / 8;
    return -((-v + 7) / 8);
  endfunction

  function automatic int clip(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic model_cur(input int bc, input int br);
    for (int r = 0; r < 16; r++)
      for (int w = 0; w < 2; w++)
        exp_cur_q.push_back(int'(((br * 16 + r) * FW + bc * 16 + 8 * w) / 8));
  endtask

  task automatic model_sw(input int sx, input int sy);
    int x0, py, px;
    x0 = floor8(sx);
    for (int r = 0; r < 24; r++)
      for (int c = 0; c < 3; c++) begin
        py = clip(sy + r, 0, FH - 1);
        px = clip((x0 + c) * 8, 0, FW - 8);
        exp_sw_q.push_back(int'((py * FW + px) / 8));
      end
  endtask

  task automatic clear_rec();
    rd_addr_q.delete();
    cur_data_q.delete();
    sw_data_q.delete();
    exp_cur_q.delete();
    exp_sw_q.delete();
    n_rd = 0; n_cur = 0; n_sw = 0;
    first_rd_cyc = -1; last_cur_cyc = -1; first_sw_cyc = -1; cf_cyc = -1;
    overlap = 1'b0;
  endtask

  task automatic check_job(input string tag);
    int unsigned all_q[$];
    all_q = {exp_cur_q, exp_sw_q};
    check({tag, "_nrd"}, 96'(rd_addr_q.size()), 96'(all_q.size()));
    check({tag, "_ncur"}, 96'(cur_data_q.size()), 96'(exp_cur_q.size()));
    check({tag, "_nsw"}, 96'(sw_data_q.size()), 96'(exp_sw_q.size()));
    check({tag, "_rd_per_we"}, 96'(n_rd), 96'(n_cur + n_sw));
    check({tag, "_overlap"}, 96'(overlap), 96'(0));
    for (int i = 0; i < all_q.size(); i++)
      check($sformatf("%s_addr%0d", tag, i),
            (i < rd_addr_q.size()) ? 96'(rd_addr_q[i]) : 96'hx, 96'(all_q[i]));
    for (int i = 0; i < exp_cur_q.size(); i++)
      check($sformatf("%s_cdat%0d", tag, i),
            (i < cur_data_q.size()) ? 96'(cur_data_q[i]) : 96'hx, 96'(mem_word(exp_cur_q[i])));
    for (int i = 0; i < exp_sw_q.size(); i++)
      check($sformatf("%s_sdat%0d", tag, i),
            (i < sw_data_q.size()) ? 96'(sw_data_q[i]) : 96'hx, 96'(mem_word(exp_sw_q[i])));
  endtask

  task automatic wait_idle(input string tag, input int ncur, input int nsw);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (n_cur >= ncur && n_sw >= nsw && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (2) @(negedge clk);
    check({tag, "_done"}, 96'(ok), 96'(1));
  endtask

  int start_cyc;

  task automatic do_start(input int bc, input int br);
    @(posedge clk);
    #1;
    start     = 1'b1;
    blk_col   = 5'(bc);
    blk_row   = 5'(br);
    start_cyc = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic do_req(input int sx, input int sy);
    @(posedge clk);
    #1;
    search_WE_req = 1'b1;
    sw_x = 11'(sx);
    sw_y = 11'(sy);
    @(posedge clk);
    #1;
    search_WE_req = 1'b0;
  endtask

  int bc, br, sx, sy, c1, r1, c3, r3;

  initial begin
    key           = $urandom;
    reset         = 1'b1;
    start         = 1'b0;
    blk_col       = '0;
    blk_row       = '0;
    search_WE_req = 1'b0;
    sw_x          = '0;
    sw_y          = '0;
    clear_rec();

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          96'({mem_rd, mem_addr, cur_data_in, cur_WE, search_WE, curfilled, srcfilled, busy}), 96'(0));
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Current block (1,1), 1-cycle memory.
    lat_lo = 1; lat_hi = 1;
    clear_rec();
    model_cur(1, 1);
    do_start(1, 1);
    wait_idle("cur11", 32, 0);
    check("cur11_first_rd_cyc", 96'(first_rd_cyc), 96'(start_cyc + 1));
    check("cur11_last_we_cyc", 96'(last_cur_cyc), 96'(start_cyc + 65));
    check("cur11_curfilled_cyc", 96'(cf_cyc), 96'(start_cyc + 66));
    check("cur11_curfilled", 96'(curfilled), 96'(1));
    check("cur11_srcfilled", 96'(srcfilled), 96'(0));
    check_job("cur11");

    // Top-left search window clamp.
    lat_lo = 1; lat_hi = 3;
    clear_rec();
    model_sw(-12, -4);
    do_req(-12, -4);
    wait_idle("sw_tl", 0, 72);
    check("sw_tl_srcfilled", 96'(srcfilled), 96'(1));
    check_job("sw_tl");

    // Bottom-right search window clamp.
    clear_rec();
    model_sw(340, 280);
    do_req(340, 280);
    wait_idle("sw_br", 0, 72);
    check("sw_br_srcfilled", 96'(srcfilled), 96'(1));
    check_job("sw_br");

    // Simultaneous start and search request: block first, then window.
    bc = int'($urandom_range(21, 0));
    br = int'($urandom_range(17, 0));
    sx = int'($urandom_range(420, 0)) - 40;
    sy = int'($urandom_range(340, 0)) - 40;
    clear_rec();
    model_cur(bc, br);
    model_sw(sx, sy);
    @(posedge clk);
    #1;
    start = 1'b1; blk_col = 5'(bc); blk_row = 5'(br);
    search_WE_req = 1'b1; sw_x = 11'(sx); sw_y = 11'(sy);
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 3000 && n_sw == 0; i++) @(negedge clk);
    search_WE_req = 1'b0;
    wait_idle("simul", 32, 72);
    check("simul_order", 96'(first_sw_cyc > last_cur_cyc), 96'(1));
    check("simul_curfilled", 96'(curfilled), 96'(1));
    check("simul_srcfilled", 96'(srcfilled), 96'(1));
    check_job("simul");

    // Reset mid-load with a read still outstanding.
    lat_lo = 3; lat_hi = 3;
    clear_rec();
    do_start(2, 3);
    for (int i = 0; i < 2000 && n_cur < 10; i++) @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_outputs",
          96'({mem_rd, mem_addr, cur_data_in, cur_WE, search_WE, curfilled, srcfilled, busy}), 96'(0));
    repeat (8) @(negedge clk);
    check("rst_stale_we", 96'(n_cur), 96'(10));
    check("rst_busy", 96'(busy), 96'(0));
    check("rst_idle_outputs", 96'({mem_rd, cur_WE, search_WE, curfilled, srcfilled}), 96'(0));

    // Load after reset completes normally.
    lat_lo = 1; lat_hi = 5;
    clear_rec();
    model_cur(5, 7);
    do_start(5, 7);
    wait_idle("post_rst", 32, 0);
    check("post_rst_curfilled", 96'(curfilled), 96'(1));
    check_job("post_rst");

    // Start while busy is queued; the later of two queued starts wins.
    c1 = int'($urandom_range(21, 0)); r1 = int'($urandom_range(17, 0));
    c3 = int'($urandom_range(21, 0)); r3 = int'($urandom_range(17, 0));
    clear_rec();
    model_cur(c1, r1);
    model_cur(c3, r3);
    do_start(c1, r1);
    repeat (6) @(negedge clk);
    do_start(int'($urandom_range(21, 0)), int'($urandom_range(17, 0)));
    repeat (3) @(negedge clk);
    do_start(c3, r3);
    wait_idle("pend", 64, 0);
    check("pend_curfilled", 96'(curfilled), 96'(1));
    check_job("pend");

    // Random jobs under 1..5 cycle memory latency.
    for (int k = 0; k < 4; k++) begin
      clear_rec();
      if ($urandom_range(1, 0) == 0) begin
        bc = int'($urandom_range(21, 0));
        br = int'($urandom_range(17, 0));
        model_cur(bc, br);
        do_start(bc, br);
        wait_idle($sformatf("rnd%0d", k), 32, 0);
        check($sformatf("rnd%0d_curfilled", k), 96'(curfilled), 96'(1));
      end else begin
        sx = int'($urandom_range(460, 0)) - 60;
        sy = int'($urandom_range(380, 0)) - 60;
        model_sw(sx, sy);
        do_req(sx, sy);
        wait_idle($sformatf("rnd%0d", k), 0, 72);
        check($sformatf("rnd%0d_srcfilled", k), 96'(srcfilled), 96'(1));
      end
      check_job($sformatf("rnd%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
